// File: rtl/car_ctrl_pkg.sv
// Shared types and default sizing for the carrier Doppler-search controller.
package car_ctrl_pkg;

    localparam int DEF_ACC_WIDTH     = 32;
    localparam int DEF_BIN_WIDTH     = 8;
    localparam int DEF_DWELL_WIDTH   = 16;
    localparam int DEF_ENERGY_WIDTH  = 24;
    localparam int DEF_SETTLE_CYCLES = 4;
    localparam int DEF_TMO_CYCLES    = 255;

    typedef enum logic [2:0] {
        IDLE,
        SETTLE,
        DWELL,
        WAIT_E,
        COMPARE,
        LOCK
    } car_state_t;

    function automatic logic is_busy(input car_state_t s);
        return (s == SETTLE) || (s == DWELL) || (s == WAIT_E) || (s == COMPARE);
    endfunction

endpackage

// File: rtl/car_dwell_timer.sv
// Loadable down-counter: a load of N spans exactly N cycles, flagging the
// first cycle after the load and the cycle in which the count reaches 1.
module car_dwell_timer #(
    parameter int W = 16
) (
    input  logic         rx_clk,
    input  logic         rx_rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         first,
    output logic         last
);

    logic [W-1:0] cnt_reg;
    logic         first_reg;

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            cnt_reg   <= '0;
            first_reg <= 1'b0;
        end else if (load) begin
            cnt_reg   <= load_val;
            first_reg <= 1'b1;
        end else begin
            first_reg <= 1'b0;
            if (cnt_reg != '0) begin
                cnt_reg <= cnt_reg - W'(1);
            end
        end
    end

    assign first = first_reg;
    assign last  = (cnt_reg == W'(1));

endmodule

// File: rtl/car_search_ctrl.sv
// Doppler-bin search scheduler: steps the NCO FCW over a grid, collects one
// correlator energy per bin and finally locks onto the strongest bin.
module car_search_ctrl
    import car_ctrl_pkg::*;
#(
    parameter int ACC_WIDTH     = DEF_ACC_WIDTH,
    parameter int BIN_WIDTH     = DEF_BIN_WIDTH,
    parameter int DWELL_WIDTH   = DEF_DWELL_WIDTH,
    parameter int ENERGY_WIDTH  = DEF_ENERGY_WIDTH,
    parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
    parameter int TMO_CYCLES    = DEF_TMO_CYCLES
) (
    input  logic                    rx_clk,
    input  logic                    rx_rst,
    input  logic                    rx_start,
    input  logic                    rx_abort,
    input  logic [ACC_WIDTH-1:0]    rx_fcw_start,
    input  logic [ACC_WIDTH-1:0]    rx_fcw_step,
    input  logic [BIN_WIDTH-1:0]    rx_num_bins,
    input  logic [DWELL_WIDTH-1:0]  rx_dwell_len,
    input  logic [ENERGY_WIDTH-1:0] rx_energy,
    input  logic                    rx_energy_vld,
    output logic [ACC_WIDTH-1:0]    tx_car_fcw,
    output logic                    tx_dump,
    output logic                    tx_dwell_end,
    output logic                    tx_busy,
    output logic                    tx_done,
    output logic                    tx_found,
    output logic [BIN_WIDTH-1:0]    tx_best_bin,
    output logic [ENERGY_WIDTH-1:0] tx_best_energy,
    output logic                    tx_err
);

    car_state_t state_reg, state_next;

    logic [BIN_WIDTH-1:0]    num_bins_reg, bin_idx_reg, best_bin_reg, best_bin_next;
    logic [ACC_WIDTH-1:0]    step_reg, cur_fcw_reg, best_fcw_reg, best_fcw_next;
    logic [ACC_WIDTH-1:0]    car_fcw_reg, fcw_next;
    logic [DWELL_WIDTH-1:0]  dwell_reg, tmr_val;
    logic [ENERGY_WIDTH-1:0] energy_reg, best_energy_reg, best_energy_next;
    logic                    done_reg, found_reg, err_reg;
    logic                    tmr_load, tmr_first, tmr_last;
    logic                    busy, accept, last_bin, better;

    assign busy     = is_busy(state_reg);
    assign accept   = ((state_reg == IDLE) || (state_reg == LOCK)) && rx_start && !rx_abort;
    assign last_bin = (bin_idx_reg == num_bins_reg - BIN_WIDTH'(1));
    assign fcw_next = cur_fcw_reg + step_reg;

    // Strict compare keeps the lower bin on a tie.
    assign better           = (energy_reg > best_energy_reg);
    assign best_energy_next = better ? energy_reg  : best_energy_reg;
    assign best_bin_next    = better ? bin_idx_reg : best_bin_reg;
    assign best_fcw_next    = better ? cur_fcw_reg : best_fcw_reg;

    car_dwell_timer #(
        .W(DWELL_WIDTH)
    ) u_timer (
        .rx_clk   (rx_clk),
        .rx_rst   (rx_rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .first    (tmr_first),
        .last     (tmr_last)
    );

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        if (busy && rx_abort) begin
            state_next = IDLE;
        end else begin
            case (state_reg)
                IDLE, LOCK: begin
                    if (accept) begin
                        if (rx_num_bins == '0) begin
                            state_next = LOCK;
                        end else begin
                            state_next = SETTLE;
                            tmr_load   = 1'b1;
                            tmr_val    = DWELL_WIDTH'(SETTLE_CYCLES);
                        end
                    end
                end
                SETTLE: begin
                    if (tmr_last) begin
                        state_next = DWELL;
                        tmr_load   = 1'b1;
                        tmr_val    = dwell_reg;
                    end
                end
                DWELL: begin
                    if (tmr_last) begin
                        state_next = WAIT_E;
                        tmr_load   = 1'b1;
                        tmr_val    = DWELL_WIDTH'(TMO_CYCLES);
                    end
                end
                WAIT_E: begin
                    if (rx_energy_vld || tmr_last) begin
                        state_next = COMPARE;
                    end
                end
                COMPARE: begin
                    if (last_bin) begin
                        state_next = LOCK;
                    end else begin
                        state_next = SETTLE;
                        tmr_load   = 1'b1;
                        tmr_val    = DWELL_WIDTH'(SETTLE_CYCLES);
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge rx_clk or negedge rx_rst) begin
        if (!rx_rst) begin
            num_bins_reg    <= '0;
            step_reg        <= '0;
            dwell_reg       <= '0;
            bin_idx_reg     <= '0;
            cur_fcw_reg     <= '0;
            car_fcw_reg     <= '0;
            energy_reg      <= '0;
            best_energy_reg <= '0;
            best_bin_reg    <= '0;
            best_fcw_reg    <= '0;
            done_reg        <= 1'b0;
            found_reg       <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                num_bins_reg    <= rx_num_bins;
                step_reg        <= rx_fcw_step;
                dwell_reg       <= (rx_dwell_len == '0) ? DWELL_WIDTH'(1) : rx_dwell_len;
                bin_idx_reg     <= '0;
                cur_fcw_reg     <= rx_fcw_start;
                energy_reg      <= '0;
                best_energy_reg <= '0;
                best_bin_reg    <= '0;
                best_fcw_reg    <= '0;
                err_reg         <= 1'b0;
                found_reg       <= 1'b0;
                if (rx_num_bins == '0) begin
                    done_reg <= 1'b1;
                end else begin
                    car_fcw_reg <= rx_fcw_start;
                end
            end else if (!rx_abort) begin
                case (state_reg)
                    WAIT_E: begin
                        if (rx_energy_vld) begin
                            energy_reg <= rx_energy;
                        end else if (tmr_last) begin
                            energy_reg <= '0;
                            err_reg    <= 1'b1;
                        end
                    end
                    COMPARE: begin
                        best_energy_reg <= best_energy_next;
                        best_bin_reg    <= best_bin_next;
                        best_fcw_reg    <= best_fcw_next;
                        if (last_bin) begin
                            done_reg  <= 1'b1;
                            found_reg <= (best_energy_next != '0);
                            // With no energy anywhere the NCO stays on the last bin.
                            if (best_energy_next != '0) begin
                                car_fcw_reg <= best_fcw_next;
                            end
                        end else begin
                            bin_idx_reg <= bin_idx_reg + BIN_WIDTH'(1);
                            cur_fcw_reg <= fcw_next;
                            car_fcw_reg <= fcw_next;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign tx_car_fcw     = car_fcw_reg;
    assign tx_dump        = (state_reg == DWELL) && tmr_first;
    assign tx_dwell_end   = (state_reg == DWELL) && tmr_last;
    assign tx_busy        = busy;
    assign tx_done        = done_reg;
    assign tx_found       = found_reg;
    assign tx_best_bin    = best_bin_reg;
    assign tx_best_energy = best_energy_reg;
    assign tx_err         = err_reg;

endmodule

// File: tb/tb_car_search_ctrl.sv
// Self-checking bench for car_search_ctrl: directed and randomized searches
// against a per-search reference built from bin timing and energy lists.
module tb_car_search_ctrl;

    localparam int S   = 4;
    localparam int TMO = 255;

    logic        rx_clk = 1'b0;
    logic        rx_rst = 1'b0;
    logic        rx_start = 1'b0;
    logic        rx_abort = 1'b0;
    logic [31:0] rx_fcw_start = '0;
    logic [31:0] rx_fcw_step = '0;
    logic [7:0]  rx_num_bins = '0;
    logic [15:0] rx_dwell_len = '0;
    logic [23:0] rx_energy = '0;
    logic        rx_energy_vld = 1'b0;

    logic [31:0] tx_car_fcw;
    logic        tx_dump, tx_dwell_end, tx_busy, tx_done, tx_found, tx_err;
    logic [7:0]  tx_best_bin;
    logic [23:0] tx_best_energy;

    int          n_assert = 0;
    int          n_fail = 0;
    int          energies[16];
    logic [31:0] model_fcw = '0;

    always #5 rx_clk = ~rx_clk;

    car_search_ctrl #(
        .ACC_WIDTH     (32),
        .BIN_WIDTH     (8),
        .DWELL_WIDTH   (16),
        .ENERGY_WIDTH  (24),
        .SETTLE_CYCLES (S),
        .TMO_CYCLES    (TMO)
    ) dut (
        .rx_clk         (rx_clk),
        .rx_rst         (rx_rst),
        .rx_start       (rx_start),
        .rx_abort       (rx_abort),
        .rx_fcw_start   (rx_fcw_start),
        .rx_fcw_step    (rx_fcw_step),
        .rx_num_bins    (rx_num_bins),
        .rx_dwell_len   (rx_dwell_len),
        .rx_energy      (rx_energy),
        .rx_energy_vld  (rx_energy_vld),
        .tx_car_fcw     (tx_car_fcw),
        .tx_dump        (tx_dump),
        .tx_dwell_end   (tx_dwell_end),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .tx_found       (tx_found),
        .tx_best_bin    (tx_best_bin),
        .tx_best_energy (tx_best_energy),
        .tx_err         (tx_err)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] bin_fcw(input logic [31:0] fs, input logic [31:0] fst, input int k);
        return fs + fst * 32'(k);
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_fcw"},    tx_car_fcw, 0);
        check({tag, "_dump"},   tx_dump, 0);
        check({tag, "_dend"},   tx_dwell_end, 0);
        check({tag, "_busy"},   tx_busy, 0);
        check({tag, "_done"},   tx_done, 0);
        check({tag, "_found"},  tx_found, 0);
        check({tag, "_bbin"},   tx_best_bin, 0);
        check({tag, "_benergy"}, tx_best_energy, 0);
        check({tag, "_err"},    tx_err, 0);
    endtask

    // Runs one search; cycle numbers are counted from the cycle rx_start is sampled.
    task automatic run_search(input string name, input int n, input logic [31:0] fs,
                              input logic [31:0] fst, input int dwell, input int delay,
                              input int withhold, input int abort_bin);
        int d, st, w, done_step, mx, exp_bin, dumps, ends, vld_at, vld_bin, step, e;
        int exp_dump[16];
        int exp_end[16];
        logic done_seen, found, exp_err, stray;
        logic [31:0] exp_fcw;

        d = (dwell == 0) ? 1 : dwell;
        st = 0;
        mx = 0;
        exp_err = 1'b0;
        for (int k = 0; k < n; k++) begin
            w = withhold[k] ? TMO : delay;
            exp_dump[k] = st + S + 1;
            exp_end[k]  = st + S + d;
            st += S + d + w + 1;
            e = withhold[k] ? 0 : energies[k];
            if (e > mx) mx = e;
            if (withhold[k]) exp_err = 1'b1;
        end
        exp_bin = 0;
        for (int k = n - 1; k >= 0; k--) begin
            e = withhold[k] ? 0 : energies[k];
            if (mx > 0 && e == mx) exp_bin = k;
        end
        done_step = st + 1;
        found = (mx > 0);
        if (n == 0)     exp_fcw = model_fcw;
        else if (found) exp_fcw = bin_fcw(fs, fst, exp_bin);
        else            exp_fcw = bin_fcw(fs, fst, n - 1);

        @(negedge rx_clk);
        rx_fcw_start = fs;
        rx_fcw_step  = fst;
        rx_num_bins  = 8'(n);
        rx_dwell_len = 16'(dwell);
        rx_start     = 1'b1;
        dumps = 0; ends = 0; vld_at = -1; vld_bin = 0; step = 0; done_seen = 1'b0;

        while (!done_seen && step < done_step + 4) begin
            @(negedge rx_clk);
            step++;
            rx_start     = (n != 0 && step == 2);
            rx_fcw_start = $urandom;
            rx_fcw_step  = $urandom;
            rx_num_bins  = 8'($urandom);
            rx_dwell_len = 16'($urandom);
            if (step == 1) check({name, "_busy_start"}, tx_busy, (n != 0));
            if (tx_dump) begin
                if (dumps < n) begin
                    check({name, "_dump_cycle"}, step, exp_dump[dumps]);
                    check({name, "_dump_fcw"}, tx_car_fcw, bin_fcw(fs, fst, dumps));
                end else begin
                    check({name, "_extra_dump"}, dumps, n);
                end
                dumps++;
            end
            if (tx_dwell_end) begin
                if (ends < n) begin
                    check({name, "_dwell_end_cycle"}, step, exp_end[ends]);
                    if (!withhold[ends]) begin
                        vld_at  = step + delay;
                        vld_bin = ends;
                    end
                end
                ends++;
            end
            if (tx_done) begin
                done_seen = 1'b1;
                check({name, "_done_cycle"}, step, done_step);
                check({name, "_best_bin"}, tx_best_bin, exp_bin);
                check({name, "_best_energy"}, tx_best_energy, mx);
                check({name, "_found"}, tx_found, found);
                check({name, "_lock_fcw"}, tx_car_fcw, exp_fcw);
                check({name, "_err"}, tx_err, exp_err);
                check({name, "_busy_lock"}, tx_busy, 0);
                check({name, "_bins_visited"}, dumps, n);
            end
            if (abort_bin >= 0 && tx_dump && dumps == abort_bin + 1) begin
                rx_abort = 1'b1;
                rx_energy_vld = 1'b0;
                @(negedge rx_clk);
                rx_abort = 1'b0;
                check({name, "_abort_busy"}, tx_busy, 0);
                check({name, "_abort_fcw"}, tx_car_fcw, bin_fcw(fs, fst, abort_bin));
                stray = 1'b0;
                for (int i = 0; i < 40; i++) begin
                    @(negedge rx_clk);
                    if (tx_done || tx_dump || tx_busy) stray = 1'b1;
                end
                check({name, "_abort_quiet"}, stray, 0);
                model_fcw = bin_fcw(fs, fst, abort_bin);
                $display("search %s: aborted in bin %0d, fcw=0x%08h", name, abort_bin, tx_car_fcw);
                return;
            end
            // A valid pulse in the first dwell cycle must be ignored.
            if (step == vld_at) begin
                rx_energy_vld = 1'b1;
                rx_energy     = 24'(energies[vld_bin]);
            end else if (tx_dump) begin
                rx_energy_vld = 1'b1;
                rx_energy     = 24'hFFFFFF;
            end else begin
                rx_energy_vld = 1'b0;
                rx_energy     = 24'($urandom);
            end
        end
        check({name, "_done_seen"}, done_seen, 1);
        @(negedge rx_clk);
        rx_energy_vld = 1'b0;
        rx_start = 1'b0;
        check({name, "_done_pulse"}, tx_done, 0);
        check({name, "_hold_fcw"}, tx_car_fcw, exp_fcw);
        model_fcw = exp_fcw;
        $display("search %s: bins=%0d best_bin=%0d energy=%0d found=%0d fcw=0x%08h err=%0d",
                 name, n, tx_best_bin, tx_best_energy, tx_found, tx_car_fcw, tx_err);
    endtask

    initial begin
        logic seen, stray;
        int   n;

        repeat (3) @(negedge rx_clk);
        check_all_zero("reset");
        rx_rst = 1'b1;

        energies[0] = 10; energies[1] = 50; energies[2] = 30; energies[3] = 20;
        run_search("basic", 4, 32'h0100_0000, 32'h0001_0000, 8, 2, 0, -1);

        for (int k = 0; k < 3; k++) energies[k] = 7;
        run_search("tie_wrap", 3, 32'hFFFF_0000, 32'h0001_0000, 5, 1, 0, -1);

        energies[0] = 99; energies[1] = 40;
        run_search("timeout", 2, 32'h0200_0000, 32'h0000_1000, 4, 2, 1, -1);

        for (int k = 0; k < 5; k++) energies[k] = int'($urandom_range(1, 100));
        run_search("abort", 5, 32'h0300_0000, 32'h0010_0000, 6, 2, 0, 2);

        @(negedge rx_clk);
        rx_start = 1'b1;
        rx_abort = 1'b1;
        @(negedge rx_clk);
        rx_start = 1'b0;
        rx_abort = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (tx_busy || tx_dump || tx_done) stray = 1'b1;
            @(negedge rx_clk);
        end
        check("start_abort_ignored", stray, 0);
        check("start_abort_fcw", tx_car_fcw, model_fcw);
        $display("start+abort same cycle: busy=%0d fcw=0x%08h", tx_busy, tx_car_fcw);

        // Reset asserted while waiting for energy.
        @(negedge rx_clk);
        rx_fcw_start = 32'h0444_0000;
        rx_fcw_step  = 32'h0000_0100;
        rx_num_bins  = 8'd3;
        rx_dwell_len = 16'd3;
        rx_start     = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge rx_clk);
            rx_start = 1'b0;
            if (tx_dwell_end) seen = 1'b1;
        end
        check("rst_mid_reached_wait", seen, 1);
        @(negedge rx_clk);
        #1 rx_rst = 1'b0;
        #1 check_all_zero("rst_mid");
        @(negedge rx_clk);
        rx_rst = 1'b1;
        model_fcw = '0;
        $display("reset during energy wait: busy=%0d fcw=0x%08h", tx_busy, tx_car_fcw);

        energies[0] = 3; energies[1] = 9; energies[2] = 9;
        run_search("after_reset", 3, 32'h0555_0000, 32'hFFFF_F000, 3, 3, 0, -1);

        run_search("bins0", 0, 32'h0666_0000, 32'h0000_0001, 4, 1, 0, -1);

        energies[0] = 1; energies[1] = 2; energies[2] = 12;
        run_search("dwell0", 3, 32'h0777_0000, 32'h0001_0000, 0, 1, 0, -1);

        for (int k = 0; k < 3; k++) energies[k] = 0;
        run_search("zero_energy", 3, 32'h0888_0000, 32'h0002_0000, 2, 2, 0, -1);

        for (int r = 0; r < 6; r++) begin
            n = int'($urandom_range(1, 6));
            for (int k = 0; k < n; k++) energies[k] = int'($urandom_range(0, 15));
            run_search("random", n, $urandom, $urandom, int'($urandom_range(0, 5)),
                       int'($urandom_range(1, 3)), int'($urandom_range(0, 15)) & ((r == 3) ? 2 : 0), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
